// File: rtl/johnson_decoder.sv
// johnson_decoder: decodes an 8-bit Johnson code to a phase index, flags illegal codes and bad steps, and tracks lock.
// Define JDEC_SYNC_EN to put a two-flop synchronizer in front of code_in/sample_en.
module johnson_decoder #(
    parameter int LOCK_RUN   = 4,
    parameter int MISS_MAX   = 2,
    parameter int ALLOW_HOLD = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] code_in,
    input  logic       sample_en,
    input  logic       clr_err,
    output logic [3:0] phase,
    output logic       phase_vld,
    output logic       code_err,
    output logic       seq_err,
    output logic       locked,
    output logic [7:0] err_cnt
);
    typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;
    state_t     state;
    logic [7:0] code_q;
    logic       smp_q;
    logic [3:0] run;
    logic [2:0] miss;
    logic [3:0] dec;
    logic       legal, good, hold, step_ok, err_ev;
`ifdef JDEC_SYNC_EN
    logic [7:0] code_s1, code_s2;
    logic       smp_s1, smp_s2;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            code_s1 <= '0;
            code_s2 <= '0;
            code_q  <= '0;
            smp_s1  <= 1'b0;
            smp_s2  <= 1'b0;
            smp_q   <= 1'b0;
        end else begin
            code_s1 <= code_in;
            code_s2 <= code_s1;
            code_q  <= code_s2;
            smp_s1  <= sample_en;
            smp_s2  <= smp_s1;
            smp_q   <= smp_s2;
        end
`else
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            code_q <= '0;
            smp_q  <= 1'b0;
        end else begin
            code_q <= code_in;
            smp_q  <= sample_en;
        end
`endif
    // Phases 0..8 fill ones from the MSB, phases 9..15 drain them from the MSB.
    function automatic logic [7:0] jcode(input int k);
        return (k <= 8) ? ~(8'hFF >> k) : (8'hFF >> (k - 8));
    endfunction
    always_comb begin
        legal = 1'b0;
        dec   = '0;
        for (int k = 0; k < 16; k++)
            if (code_q == jcode(k)) begin
                legal = 1'b1;
                dec   = 4'(k);
            end
    end
    assign good    = legal && (dec == phase + 4'd1);
    assign hold    = legal && (dec == phase);
    assign step_ok = good || (ALLOW_HOLD != 0 && hold);
    assign err_ev  = smp_q && state != HUNT && !step_ok;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= HUNT;
            phase     <= '0;
            phase_vld <= 1'b0;
            code_err  <= 1'b0;
            seq_err   <= 1'b0;
            locked    <= 1'b0;
            err_cnt   <= '0;
            run       <= '0;
            miss      <= '0;
        end else begin
            phase_vld <= smp_q;
            code_err  <= smp_q && !legal;
            seq_err   <= smp_q && legal && state != HUNT && !step_ok;
            if (smp_q && legal) phase <= dec;
            err_cnt <= clr_err ? 8'd0 : (err_ev && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
            if (smp_q)
                case (state)
                    HUNT:
                        if (legal) begin
                            state <= TRACK;
                            run   <= '0;
                        end
                    TRACK:
                        if (!legal) state <= HUNT;
                        else if (!step_ok) run <= '0;
                        else if (good) begin
                            if (run == 4'(LOCK_RUN - 1)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                miss   <= '0;
                            end else run <= run + 4'd1;
                        end
                    LOCKED:
                        if (step_ok) miss <= '0;
                        else if (miss == 3'(MISS_MAX - 1)) begin
                            state  <= HUNT;
                            locked <= 1'b0;
                        end else miss <= miss + 3'd1;
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
        end
endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Receive-side companion to the 8-bit Johnson counter. Samples an 8-bit Johnson-coded word, decodes it to a 4-bit phase index (0–15), and flags illegal codes and out-of-sequence steps. A hunt/track/lock state machine reports when the incoming stream is a clean, continuous Johnson sequence. It sits between `ui_in` (code source) and `uo_out` (status) in the tile top.

## Interface

Parameters:
- `LOCK_RUN`, default 4: consecutive good steps in TRACK needed to enter LOCKED (range 1–15).
- `MISS_MAX`, default 2: consecutive errors in LOCKED that drop back to HUNT (range 1–7).
- `ALLOW_HOLD`, default 1: 1 = a repeated phase is legal; 0 = a repeated phase is a sequence error.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `code_in` in 8: Johnson-coded word.
- `sample_en` in 1: capture `code_in` on this edge.
- `clr_err` in 1: synchronous clear of `err_cnt`.
- `phase` out 4: last decoded phase.
- `phase_vld` out 1: one-cycle pulse when `phase`, `code_err` and `seq_err` update.
- `code_err` out 1: one-cycle pulse when the sample was an illegal code.
- `seq_err` out 1: one-cycle pulse when the sample was legal but not a legal step.
- `locked` out 1: high in the LOCKED state.
- `err_cnt` out 8: saturating count of errors while in TRACK or LOCKED.

## Operation

- Legal codes (16 total), matching the counter's run from reset:
  - Phase k = 0..8: k ones, MSB-aligned. Phase 0 = 0x00, phase 1 = 0x80, phase 2 = 0xC0, phase 8 = 0xFF.
  - Phase k = 9..15: 0xFF >> (k−8). Phase 9 = 0x7F, phase 15 = 0x01.
  - Every other value is illegal. On an illegal code, `phase` holds its previous value.
- Legal step: next phase = (prev + 1) mod 16, so 15→0 wraps with no error. Same phase is also legal when `ALLOW_HOLD`=1.
- State machine (2-bit state; reset to HUNT):
  - **HUNT**
    - Legal code: store it as the reference phase, clear the run counter, go to TRACK.
    - Illegal code: `code_err` pulses, stay in HUNT.
    - No step check is made and `err_cnt` does not count.
  - **TRACK**
    - Good step: run counter +1. At `LOCK_RUN` good steps, go to LOCKED and clear the miss counter.
    - Illegal code: go to HUNT; `err_cnt` +1.
    - Legal but bad step: `seq_err` pulses, run counter is cleared, the new phase becomes the reference, stay in TRACK; `err_cnt` +1.
  - **LOCKED**
    - Any error: miss counter +1 and `err_cnt` +1. Reaching `MISS_MAX` consecutive misses goes to HUNT.
    - Good step: miss counter is cleared.
    - After a bad step that is still legal, the new phase becomes the reference.
    - A hold does not count as a step for `LOCK_RUN`. It does clear the miss counter.
- `err_cnt` saturates at 255.
  - `clr_err` takes priority: if `clr_err` and an error land on the same edge, the result is 0.
- Reset mid-operation: every register returns to its reset value immediately (asynchronous reset), including any capture already in the pipeline.

## Timing

- Reset values: `phase`=0, `phase_vld`=0, `code_err`=0, `seq_err`=0, `locked`=0, `err_cnt`=0, state HUNT, run/miss counters 0.
- Pipeline:
  - Edge N with `sample_en`=1: `code_in` is registered.
  - Edge N+1: the outputs (`phase`, `phase_vld`, `code_err`, `seq_err`) and the state/counter updates are registered.
  - `locked` changes on the same edge as the `phase_vld` that caused the transition.
- Latency from sample edge to outputs is 1 edge. Each sample produces exactly one `phase_vld` pulse.
- Back-to-back samples are allowed; throughput is one sample per cycle.
- With `sample_en`=0, nothing updates and all pulses are 0.
- `err_cnt` updates on the same edge as the error pulse.

## Configuration

- `JDEC_SYNC_EN`:
  - Defined: `code_in` and `sample_en` first pass through a two-flop synchronizer, for an asynchronous code source. Latency becomes 3 edges from the edge where the inputs are applied.
  - Undefined: inputs are registered directly with 1-edge latency, as above.
  - Function is otherwise identical.

## Test plan

- Reset with defaults, then sample 0x00, 0x80, 0xC0, 0xE0, 0xF0 on consecutive cycles → `phase` 0,1,2,3,4; no error pulses; `locked` rises on the `phase_vld` for 0xF0 (4th good step).
- Locked at phase 15 (0x01), sample 0x00 → `phase`=0, no `seq_err`, stays locked. Repeat 0x00 → no error (`ALLOW_HOLD`=1).
- Locked at phase 1 (0x80), sample 0xE0 → `seq_err` pulse, `phase`=3, `err_cnt`=1, still locked. Then sample 0x5A → `code_err`, `err_cnt`=2, `locked` falls (`MISS_MAX`=2).
- In TRACK, sample 0x5A → `code_err`, state HUNT, `err_cnt`+1. In HUNT, sample 0x5A → `code_err`, `err_cnt` unchanged.
- Force 260 errors in TRACK → `err_cnt` holds at 255. Assert `clr_err` on the same edge as an error → `err_cnt`=0.
- Assert `rst_n`=0 while locked mid-stream with a sample in flight → all outputs 0 immediately, no `phase_vld` after release. Repeat the first scenario with `JDEC_SYNC_EN` defined → identical outputs, 2 edges later.
